muldiv_sequencer: RTL and testbench
===================================

# muldiv_sequencer

Iterative RV32M multiply/divide unit with its own sequencing FSM, sitting beside the main ALU in the execute stage. When the decoder flags an M-extension instruction it pulses `start`. The block then stalls the pipeline, runs a radix-2 shift-add multiply or a restoring divide over WIDTH cycles, applies the sign fix-up, and presents the result with a one-cycle `done` pulse. Division-by-zero and signed-overflow cases bypass the iteration through a fast path.

## Interface
- `WIDTH`, default 32: operand/result width. The iteration counter is $clog2(WIDTH) bits.
- `clk` input 1: the single clock; all state updates on its rising edge.
- `reset` input 1: synchronous, active-high; sampled on the rising edge of `clk`.
- `start` input 1: request; sampled only in IDLE.
- `Funct3` input 3: RV32M op.
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU
- `SrcA` input WIDTH: rs1 (multiplicand/dividend); sampled with `start`.
- `SrcB` input WIDTH: rs2 (multiplier/divisor); sampled with `start`.
- `flush` input 1: abort the current operation (branch mispredict/trap).
- `Result` output WIDTH: registered result; holds until the next `done`.
- `done` output 1: one-cycle pulse; `Result` valid in that cycle.
- `busy` output 1: high whenever state ≠ IDLE.
- `Stall` output 1: pipeline hold request.
- `Illegal` output 1: valid with `done`; high for an unsupported op (see Configuration).

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE, `start`=1:
  - Latch Funct3, operand magnitudes and sign flags; clear the accumulator.
  - Counter := 0; go to CALC.
  - Exception: a fast-path case goes directly to DONE.
- Operand signedness:
  - Signed: MULH (both operands), MULHSU (A only), DIV/REM (both).
  - Unsigned: MULHU, DIVU, REMU; MUL ignores sign.
- CALC, one iteration per cycle, counter++; at counter = WIDTH-1 go to FIX.
  - Multiply: 2·WIDTH-bit product register. If the multiplier LSB is set, add the multiplicand to the upper half, then shift right by 1.
  - Divide: shift the remainder:quotient pair left by 1. Trial-subtract the divisor; if the result is non-negative, keep it and set the quotient LSB.
- FIX:
  - Negate the product if the operand signs differ (signed ops only).
  - Negate the quotient if the signs differ; negate the remainder if the dividend is negative.
  - Select the output: MUL → low WIDTH bits; MULH/MULHSU/MULHU → high WIDTH bits; DIV/DIVU → quotient; REM/REMU → remainder.
  - Register into `Result`; go to DONE.
- DONE: `done`=1; return to IDLE on the next edge.
- Fast path (IDLE → DONE in one edge):
  - Divisor = 0: DIV/DIVU → all ones; REM/REMU → SrcA.
  - DIV with SrcA = −2^(WIDTH−1) and SrcB = −1: result SrcA. REM in the same case: result 0.
- `start` is ignored in CALC, FIX and DONE; no queuing.
- `Stall` = (IDLE & `start`) | CALC | FIX. `Stall` is low in DONE so the pipeline advances and captures `Result`.
- `flush` in CALC or FIX: return to IDLE on the next edge. No `done` is issued and `Result` is unchanged. `flush` in IDLE together with `start` drops the request.
- Priority: `reset` > `flush` > `start`.

## Timing
- Reset values:
  - State IDLE, counter 0.
  - `Result` 0, `done` 0, `busy` 0, `Illegal` 0.
  - `Stall` forced to 0 while `reset` is high.
- Latency (start sampled at edge k):
  - Iterative ops: CALC edges k+1…k+WIDTH, FIX edge k+WIDTH+1. `done` is high in the cycle after edge k+WIDTH+1, i.e. 34 cycles after the start cycle for WIDTH = 32.
  - Fast path: `done` is high in the cycle after edge k.
- Back-to-back: the earliest next `start` is accepted in the cycle after the `done` cycle. Throughput is 1 op per WIDTH+3 cycles.
- Reset mid-operation: state IDLE on the next edge; no `done`.

## Configuration
- `RV_MULDIV_DIV_EN` defined:
  - Division/remainder datapath and the fast path compiled in.
  - `Illegal` tied to 0.
- `RV_MULDIV_DIV_EN` undefined:
  - Divider logic removed.
  - Funct3[2] = 1 takes the fast path: `Result` = 0, `Illegal` = 1 with `done` one cycle after start.
  - Multiply ops are unaffected.

## Test plan
- MUL, SrcA = 7, SrcB = −3 (0xFFFFFFFD) → `Result` 0xFFFFFFEB; `done` 34 cycles after start; `Stall` high for cycles 0–33.
- MULH 0x80000000 × 0x80000000 → 0x40000000; MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE; MULHSU −1 × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV −7 / 2 → 0xFFFFFFFD; REM −7 / 2 → 0xFFFFFFFF; DIVU 100 / 7 → 14; REMU 100 / 7 → 2.
- DIVU x / 0 → 0xFFFFFFFF; REM 5 / 0 → 5; DIV 0x80000000 / −1 → 0x80000000. All three with `done` in the cycle after start.
- `flush` at CALC cycle 10 → IDLE next edge, no `done`, `Result` keeps its prior value. A new `start` while busy is ignored.
- `reset` asserted at cycle 20 of a DIV → all outputs at reset values next cycle. With `RV_MULDIV_DIV_EN` undefined, DIV 9 / 3 → `Result` 0, `Illegal` 1 after 1 cycle.

Source files
------------

// File: rtl/muldiv_sequencer_if.sv
// rtl/muldiv_sequencer_if.sv - request/result bundle between execute stage and muldiv_sequencer
interface muldiv_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       Funct3;
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic             flush;
  logic [WIDTH-1:0] Result;
  logic             done;
  logic             busy;
  logic             Stall;
  logic             Illegal;

  modport master (
    output start, Funct3, SrcA, SrcB, flush,
    input  Result, done, busy, Stall, Illegal
  );

  modport slave (
    input  start, Funct3, SrcA, SrcB, flush,
    output Result, done, busy, Stall, Illegal
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - iterative RV32M multiply/divide unit with sequencing FSM
// Divider datapath and its fast path are compiled in only when RV_MULDIV_DIV_EN is defined.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  muldiv_sequencer_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]         state;
  logic [CW-1:0]      cnt;
  logic [2:0]         op;
  logic               sign_a;
  logic               sign_b;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   result_q;

  logic               in_sign_a;
  logic               in_sign_b;
  logic [WIDTH-1:0]   in_mag_a;
  logic [WIDTH-1:0]   in_mag_b;
  logic               fast;
  logic [WIDTH-1:0]   fast_result;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [2*WIDTH-1:0] step_next;
  logic [2*WIDTH-1:0] acc_init;
  logic [WIDTH-1:0]   fix_result;

  // Sign flags are only raised for the operands an op treats as signed; MUL stays unsigned.
  always_comb begin
    in_sign_a = 1'b0;
    in_sign_b = 1'b0;
    case (bus.Funct3)
      3'b001, 3'b100, 3'b110: begin
        in_sign_a = bus.SrcA[WIDTH-1];
        in_sign_b = bus.SrcB[WIDTH-1];
      end
      3'b010:  in_sign_a = bus.SrcA[WIDTH-1];
      default: ;
    endcase
    in_mag_a = in_sign_a ? -bus.SrcA : bus.SrcA;
    in_mag_b = in_sign_b ? -bus.SrcB : bus.SrcB;
  end

  // Product register: upper half accumulates, lower half holds the multiplier being shifted out.
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_a} : {(WIDTH+1){1'b0}});
    mul_next = {mul_sum, acc[WIDTH-1:1]};
    prod_fix = (sign_a ^ sign_b) ? -acc : acc;
  end

`ifdef RV_MULDIV_DIV_EN
  localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] div_next;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  // Remainder sits in the upper half, quotient bits shift in at the bottom.
  always_comb begin
    div_shift = acc[2*WIDTH-1:WIDTH-1];
    div_diff  = div_shift - {1'b0, mag_b};
    div_next  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    quo_fix   = (sign_a ^ sign_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix   = sign_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    fast        = 1'b0;
    fast_result = bus.SrcA;
    if (bus.Funct3[2] && bus.SrcB == '0) begin
      fast        = 1'b1;
      fast_result = bus.Funct3[1] ? bus.SrcA : '1;
    end else if (bus.Funct3[2] && !bus.Funct3[0] && bus.SrcA == MIN_INT && bus.SrcB == '1) begin
      fast        = 1'b1;
      fast_result = bus.Funct3[1] ? '0 : bus.SrcA;
    end
  end

  always_comb begin
    step_next  = op[2] ? div_next : mul_next;
    acc_init   = {{WIDTH{1'b0}}, (bus.Funct3[2] ? in_mag_a : in_mag_b)};
    fix_result = prod_fix[2*WIDTH-1:WIDTH];
    if (op == 3'b000)
      fix_result = prod_fix[WIDTH-1:0];
    else if (op[2])
      fix_result = op[1] ? rem_fix : quo_fix;
  end

  assign bus.Illegal = 1'b0;
`else
  logic illegal_q;

  always_comb begin
    fast        = bus.Funct3[2];
    fast_result = '0;
    step_next   = mul_next;
    acc_init    = {{WIDTH{1'b0}}, in_mag_b};
    fix_result  = (op == 3'b000) ? prod_fix[WIDTH-1:0] : prod_fix[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk) begin
    if (reset)
      illegal_q <= 1'b0;
    else if (state == IDLE && bus.start && !bus.flush)
      illegal_q <= fast;
  end

  assign bus.Illegal = illegal_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      op       <= '0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      mag_a    <= '0;
      mag_b    <= '0;
      acc      <= '0;
      result_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start && !bus.flush) begin
            op     <= bus.Funct3;
            sign_a <= in_sign_a;
            sign_b <= in_sign_b;
            mag_a  <= in_mag_a;
            mag_b  <= in_mag_b;
            cnt    <= '0;
            if (fast) begin
              result_q <= fast_result;
              state    <= DONE;
            end else begin
              acc   <= acc_init;
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (bus.flush) begin
            state <= IDLE;
          end else begin
            acc <= step_next;
            cnt <= cnt + 1'b1;
            if (cnt == CW'(WIDTH-1))
              state <= FIX;
          end
        end
        FIX: begin
          if (!bus.flush)
            result_q <= fix_result;
          state <= bus.flush ? IDLE : DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.Result = result_q;
  assign bus.done   = (state == DONE);
  assign bus.busy   = (state != IDLE);
  assign bus.Stall  = !reset && ((state == IDLE && bus.start) || state == CALC || state == FIX);
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - directed-vector bench for muldiv_sequencer
module tb_muldiv_sequencer;
`ifdef RV_MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  muldiv_sequencer_if #(.WIDTH(32)) bus ();
  muldiv_sequencer #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_checks = 0;
  int n_pass   = 0;
  vec_t vq[$];
  logic [31:0] last_result;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] res, input int lat,
                        input logic ill, input int poke);
    int cyc;
    int stall_hi;
    bit seen;
    @(negedge clk);
    bus.start = 1'b1; bus.Funct3 = f3; bus.SrcA = a; bus.SrcB = b;
    #1;
    stall_hi = bus.Stall ? 1 : 0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (bus.done) seen = 1'b1;
      else begin
        if (bus.Stall) stall_hi++;
        if (cyc == poke) begin
          bus.start = 1'b1; bus.Funct3 = 3'b011; bus.SrcA = 32'hFFFF_FFFF; bus.SrcB = 32'hFFFF_FFFF;
        end else bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
    check({tag, "_latency"}, 32'(cyc), 32'(lat));
    check({tag, "_stall_cycles"}, 32'(stall_hi), 32'(lat));
    check({tag, "_stall_at_done"}, 32'(bus.Stall), 32'd0);
    check({tag, "_result"}, bus.Result, res);
    check({tag, "_illegal"}, 32'(bus.Illegal), 32'(ill));
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
    check({tag, "_busy_after"}, 32'(bus.busy), 32'd0);
    last_result = res;
  endtask

  initial begin
    int dones;
    vq.push_back('{3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34});
    vq.push_back('{3'b001, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 34});
    vq.push_back('{3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 34});
    vq.push_back('{3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 34});
    vq.push_back('{3'b000, 32'h1234_5678,  32'h10,        32'h2345_6780, 34});
    vq.push_back('{3'b100, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 34});
    vq.push_back('{3'b110, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 34});
    vq.push_back('{3'b101, 32'd100,        32'd7,         32'd14,        34});
    vq.push_back('{3'b111, 32'd100,        32'd7,         32'd2,         34});
    vq.push_back('{3'b011, 32'h1234_5678,  32'h10,        32'h1,         34});
    vq.push_back('{3'b101, 32'd1234,       32'd0,         32'hFFFF_FFFF, 1});
    vq.push_back('{3'b110, 32'd5,          32'd0,         32'd5,         1});
    vq.push_back('{3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1});
    vq.push_back('{3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0,         1});

    reset = 1'b1;
    bus.start = 1'b1; bus.flush = 1'b0; bus.Funct3 = 3'b000; bus.SrcA = '0; bus.SrcB = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_result",  bus.Result,          32'd0);
    check("rst_done",    32'(bus.done),       32'd0);
    check("rst_busy",    32'(bus.busy),       32'd0);
    check("rst_stall",   32'(bus.Stall),      32'd0);
    check("rst_illegal", 32'(bus.Illegal),    32'd0);
    bus.start = 1'b0;
    reset = 1'b0;

    foreach (vq[i]) begin
      if (vq[i].f3[2] && !DIV_EN)
        run_op($sformatf("v%0d", i), vq[i].f3, vq[i].a, vq[i].b, 32'd0, 1, 1'b1, 0);
      else
        run_op($sformatf("v%0d", i), vq[i].f3, vq[i].a, vq[i].b, vq[i].res, vq[i].lat, 1'b0, 0);
    end

    run_op("busy_start_ignored", 3'b000, 32'd6, 32'd7, 32'd42, 34, 1'b0, 5);

    @(negedge clk);
    bus.start = 1'b1; bus.Funct3 = 3'b000; bus.SrcA = 32'd3; bus.SrcB = 32'd5;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    @(negedge clk);
    check("flush_busy", 32'(bus.busy), 32'd0);
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    check("flush_no_done", 32'(dones), 32'd0);
    check("flush_result_kept", bus.Result, last_result);

    @(negedge clk);
    bus.start = 1'b1; bus.flush = 1'b1; bus.Funct3 = 3'b000; bus.SrcA = 32'd2; bus.SrcB = 32'd2;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.flush = 1'b0;
    @(negedge clk);
    check("idle_flush_drops_start", 32'(bus.busy), 32'd0);

    @(negedge clk);
    bus.start = 1'b1; bus.Funct3 = DIV_EN ? 3'b101 : 3'b011; bus.SrcA = 32'd100; bus.SrcB = 32'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (20) @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_mid_stall_forced", 32'(bus.Stall), 32'd0);
    @(negedge clk);
    check("rst_mid_result",  bus.Result,       32'd0);
    check("rst_mid_done",    32'(bus.done),    32'd0);
    check("rst_mid_busy",    32'(bus.busy),    32'd0);
    check("rst_mid_illegal", 32'(bus.Illegal), 32'd0);
    reset = 1'b0;
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    check("rst_mid_no_done", 32'(dones), 32'd0);

    run_op("after_reset", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, 1'b0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
